digit_scan_mux: RTL and testbench



---
 rtl/digit_scan_mux.sv | 108 ++++++++++
 tb/tb_digit_scan_mux.sv | 132 +++++++++++++
 2 files changed

// File: rtl/digit_scan_mux.sv
// digit_scan_mux: scans a tear-free shadow bank of digit codes onto one bus
// with a one-hot active-low anode select, paced by an internal prescaler.
module digit_scan_mux #(
    parameter int N_DIG = 6,
    parameter int DW = 4,
    parameter int DIV = 4,
    parameter logic [DW-1:0] CODE_OFF = 4'b1110,
    parameter logic [DW-1:0] CODE_BLANK = 4'b1111,
    localparam int SW = $clog2(N_DIG),
    localparam int PW = (DIV > 1) ? $clog2(DIV) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic [N_DIG*DW-1:0] din,
    input  logic                load,
    input  logic [N_DIG-1:0]    blank,
    output logic [DW-1:0]       digit,
    output logic [N_DIG-1:0]    an,
    output logic [SW-1:0]       sel,
    output logic                frame
);

    logic [PW-1:0]       pcnt;
    logic [SW-1:0]       idx;
    logic                pend;
    logic [N_DIG*DW-1:0] pbuf;
    logic [N_DIG*DW-1:0] sbuf;

    logic tick;
    logic wrap;

    assign tick = en && (pcnt == PW'(DIV - 1));
    assign wrap = tick && (idx == SW'(N_DIG - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pcnt <= '0;
            idx  <= '0;
        end else if (!en) begin
            pcnt <= '0;
            idx  <= '0;
        end else if (wrap) begin
            pcnt <= '0;
            idx  <= '0;
        end else if (tick) begin
            pcnt <= '0;
            idx  <= idx + SW'(1);
        end else begin
            pcnt <= pcnt + PW'(1);
        end
    end

    // Commit only at a frame boundary, or at once while the display is dark.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend <= 1'b0;
            pbuf <= '0;
            sbuf <= '0;
        end else begin
            if (load) begin
                pbuf <= din;
            end
            if (load && wrap) begin
                sbuf <= din;
                pend <= 1'b0;
            end else if (pend && (wrap || !en)) begin
                sbuf <= pbuf;
                pend <= load;
            end else if (load) begin
                pend <= 1'b1;
            end
        end
    end

    logic [DW-1:0]    digit_nxt;
    logic [N_DIG-1:0] an_nxt;

    always_comb begin
        digit_nxt = CODE_OFF;
        an_nxt    = '1;
        if (!en) begin
            digit_nxt = CODE_OFF;
            an_nxt    = '1;
        end else if (blank[idx]) begin
            digit_nxt = CODE_BLANK;
            an_nxt    = '1;
        end else begin
            digit_nxt = sbuf[int'(idx)*DW +: DW];
            an_nxt    = ~(N_DIG'(1) << idx);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            digit <= CODE_OFF;
            an    <= '1;
            sel   <= '0;
            frame <= 1'b0;
        end else begin
            digit <= digit_nxt;
            an    <= an_nxt;
            sel   <= idx;
            frame <= wrap;
        end
    end

endmodule

// File: tb/tb_digit_scan_mux.sv
// tb_digit_scan_mux: directed vector table plus hand-written reset sequence
// for digit_scan_mux at N_DIG=6, DW=4, DIV=4.
module tb_digit_scan_mux;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic [23:0] din = '0;
    logic        load = 1'b0;
    logic [5:0]  blank = '0;
    logic [3:0]  digit;
    logic [5:0]  an;
    logic [2:0]  sel;
    logic        frame;

    int nvec = 0;
    int nbad = 0;

    digit_scan_mux #(
        .N_DIG(6), .DW(4), .DIV(4),
        .CODE_OFF(4'b1110), .CODE_BLANK(4'b1111)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .din(din), .load(load),
        .blank(blank), .digit(digit), .an(an), .sel(sel), .frame(frame)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        en;
        logic        load;
        logic [23:0] din;
        logic [5:0]  blank;
        int          n;
        logic [3:0]  d;
        logic [5:0]  a;
        logic [2:0]  s;
        logic        f;
    } vec_t;

    vec_t tv[26];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        if (act != exp) begin
            nbad++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [3:0] d,
                           input logic [5:0] a, input logic [2:0] s,
                           input logic f);
        nvec++;
        chk({tag, ".digit"}, int'(digit), int'(d));
        chk({tag, ".an"}, int'(an), int'(a));
        chk({tag, ".sel"}, int'(sel), int'(s));
        chk({tag, ".frame"}, int'(frame), int'(f));
    endtask

    initial begin
        tv[0]  = '{1, 1, 24'h170561, 6'h00, 1,  4'h0, 6'h3E, 3'd0, 1'b0};
        tv[1]  = '{1, 0, 24'h000000, 6'h00, 23, 4'h0, 6'h1F, 3'd5, 1'b1};
        tv[2]  = '{1, 0, 24'h000000, 6'h00, 1,  4'h1, 6'h3E, 3'd0, 1'b0};
        tv[3]  = '{1, 0, 24'h000000, 6'h00, 4,  4'h6, 6'h3D, 3'd1, 1'b0};
        tv[4]  = '{1, 0, 24'h000000, 6'h00, 4,  4'h5, 6'h3B, 3'd2, 1'b0};
        tv[5]  = '{1, 0, 24'h000000, 6'h00, 4,  4'h0, 6'h37, 3'd3, 1'b0};
        tv[6]  = '{1, 0, 24'h000000, 6'h00, 4,  4'h7, 6'h2F, 3'd4, 1'b0};
        tv[7]  = '{1, 0, 24'h000000, 6'h00, 4,  4'h1, 6'h1F, 3'd5, 1'b0};
        tv[8]  = '{1, 0, 24'h000000, 6'h00, 3,  4'h1, 6'h1F, 3'd5, 1'b1};
        tv[9]  = '{1, 0, 24'h000000, 6'h00, 9,  4'h5, 6'h3B, 3'd2, 1'b0};
        tv[10] = '{1, 1, 24'h111111, 6'h00, 5,  4'h0, 6'h37, 3'd3, 1'b0};
        tv[11] = '{1, 0, 24'h000000, 6'h00, 8,  4'h1, 6'h1F, 3'd5, 1'b0};
        tv[12] = '{1, 0, 24'h000000, 6'h00, 3,  4'h1, 6'h3E, 3'd0, 1'b0};
        tv[13] = '{1, 0, 24'h000000, 6'h00, 8,  4'h1, 6'h3B, 3'd2, 1'b0};
        tv[14] = '{1, 1, 24'h222222, 6'h00, 4,  4'h1, 6'h37, 3'd3, 1'b0};
        tv[15] = '{1, 1, 24'h333333, 6'h00, 4,  4'h1, 6'h2F, 3'd4, 1'b0};
        tv[16] = '{1, 0, 24'h000000, 6'h00, 8,  4'h3, 6'h3E, 3'd0, 1'b0};
        tv[17] = '{1, 0, 24'h000000, 6'h00, 22, 4'h3, 6'h1F, 3'd5, 1'b0};
        tv[18] = '{1, 1, 24'h444444, 6'h00, 1,  4'h3, 6'h1F, 3'd5, 1'b1};
        tv[19] = '{1, 0, 24'h000000, 6'h00, 1,  4'h4, 6'h3E, 3'd0, 1'b0};
        tv[20] = '{1, 0, 24'h000000, 6'h04, 8,  4'hF, 6'h3F, 3'd2, 1'b0};
        tv[21] = '{1, 0, 24'h000000, 6'h04, 4,  4'h4, 6'h37, 3'd3, 1'b0};
        tv[22] = '{0, 0, 24'h000000, 6'h00, 1,  4'hE, 6'h3F, 3'd3, 1'b0};
        tv[23] = '{0, 1, 24'h555555, 6'h00, 3,  4'hE, 6'h3F, 3'd0, 1'b0};
        tv[24] = '{1, 0, 24'h000000, 6'h00, 1,  4'h5, 6'h3E, 3'd0, 1'b0};
        tv[25] = '{1, 0, 24'h000000, 6'h00, 4,  4'h5, 6'h3D, 3'd1, 1'b0};

        step();
        chk_all("rst_hold", 4'hE, 6'h3F, 3'd0, 1'b0);
        rst = 1'b0;
        step();
        chk_all("rst_idle", 4'hE, 6'h3F, 3'd0, 1'b0);

        for (int i = 0; i < 26; i++) begin
            en    = tv[i].en;
            blank = tv[i].blank;
            din   = tv[i].din;
            load  = tv[i].load;
            step();
            load = 1'b0;
            for (int j = 1; j < tv[i].n; j++) step();
            chk_all($sformatf("v%0d", i), tv[i].d, tv[i].a, tv[i].s,
                    tv[i].f);
        end

        din  = 24'h666666;
        load = 1'b1;
        step();
        load = 1'b0;
        step();
        #2;
        rst = 1'b1;
        #1;
        chk_all("rst_async", 4'hE, 6'h3F, 3'd0, 1'b0);
        step();
        rst = 1'b0;
        en  = 1'b1;
        for (int j = 0; j < 24; j++) step();
        chk_all("post_rst_wrap", 4'h0, 6'h1F, 3'd5, 1'b1);
        step();
        chk_all("post_rst_bank", 4'h0, 6'h3E, 3'd0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end

endmodule
